// File: rtl/mux4_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mux4_rr_arbiter
// Brief   : Round-robin arbiter/sequencer driving a shared 4-to-1 data mux
//           with a valid/ready output handshake and a per-grant burst limit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       gnt,
  output logic             s1,
  output logic             s2,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [3:0]       ack
);

  localparam logic [0:0] c_idle      = 1'b0;
  localparam logic [0:0] c_busy      = 1'b1;
  localparam logic [8:0] c_max_burst = 9'(MAX_BURST);

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [1:0] r_ptr;
  logic [7:0] r_cnt;
  logic [1:0] w_sel;
  logic [1:0] w_pick_idx;
  logic       w_accept;
  logic       w_last;
  logic       w_release;

  assign w_sel = {s1, s2};

  // Highest-priority request starting at the pointer: scan backwards so the
  // entry closest to r_ptr is the last (winning) assignment.
  always_comb begin
    w_pick_idx = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[r_ptr + 2'(i)]) begin
        w_pick_idx = r_ptr + 2'(i);
      end
    end
  end

  assign w_accept  = o_valid & o_ready;
  assign w_last    = w_accept && (({1'b0, r_cnt} + 9'd1) == c_max_burst);
  assign w_release = (r_state == c_busy) && (!req[w_sel] || w_last);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
      gnt     <= 4'b0000;
      s1      <= 1'b0;
      s2      <= 1'b0;
      r_ptr   <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_idle) begin
        if (|req) begin
          gnt      <= 4'b0001 << w_pick_idx;
          {s1, s2} <= w_pick_idx;
          r_cnt    <= 8'd0;
        end
      end else if (w_release) begin
        gnt   <= 4'b0000;
        r_ptr <= w_sel + 2'd1;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (|req)     w_state_nxt = c_busy;
      c_busy:  if (w_release) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    o_valid = 1'b0;
    ack     = 4'b0000;
    if (r_state == c_busy) begin
      o_valid = req[w_sel];
      if (req[w_sel] && o_ready) begin
        ack = gnt;
      end
    end
  end

  always_comb begin
    o = a;
    case (w_sel)
      2'd0:    o = a;
      2'd1:    o = b;
      2'd2:    o = c;
      default: o = d;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_mux4_rr_arbiter
// Brief   : Vector-table bench for mux4_rr_arbiter with a scoreboard queue.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux4_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] a, b, c, d;
  logic [3:0]       gnt;
  logic             s1, s2;
  logic [WIDTH-1:0] o;
  logic             o_valid;
  logic             o_ready;
  logic [3:0]       ack;

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt), .s1(s1), .s2(s2), .o(o),
    .o_valid(o_valid), .o_ready(o_ready), .ack(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] e_gnt;
    logic [1:0] e_sel;
    logic       e_valid;
    logic [3:0] e_ack;
  } vec_t;

  vec_t       vec[$];
  vec_t       sb[$];
  logic [7:0] dat [4];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic void add(logic r, logic [3:0] rq, logic rd, logic [3:0] g,
                              logic [1:0] s, logic v, logic [3:0] k);
    vec_t t;
    t.rst = r; t.req = rq; t.rdy = rd;
    t.e_gnt = g; t.e_sel = s; t.e_valid = v; t.e_ack = k;
    vec.push_back(t);
  endfunction

  function automatic void add_idle(logic [3:0] rq, logic [1:0] s);
    add(1'b0, rq, 1'b1, 4'b0000, s, 1'b0, 4'b0000);
  endfunction

  // Granted cycle for requester idx; acc marks an accepted beat
  function automatic void add_busy(logic [3:0] rq, logic rd, logic [1:0] idx,
                                   logic v, logic acc);
    logic [3:0] g;
    g = 4'b0001 << idx;
    add(1'b0, rq, rd, g, idx, v, acc ? g : 4'b0000);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(vec_t v, string tag);
    vec_t e;
    rst     = v.rst;
    req     = v.req;
    o_ready = v.rdy;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    chk({tag, " gnt"},     32'(gnt),        32'(e.e_gnt));
    chk({tag, " sel"},     32'({s1, s2}),   32'(e.e_sel));
    chk({tag, " o_valid"}, 32'(o_valid),    32'(e.e_valid));
    chk({tag, " ack"},     32'(ack),        32'(e.e_ack));
    chk({tag, " o"},       32'(o),          32'(dat[e.e_sel]));
  endtask

  initial begin
    vec_t hv;
    dat[0] = 8'h11; dat[1] = 8'hA5; dat[2] = 8'h3C; dat[3] = 8'hD2;
    a = dat[0]; b = dat[1]; c = dat[2]; d = dat[3];
    rst = 1'b1; req = 4'b0000; o_ready = 1'b1;

    // Reset held, then idle with no requests
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000);
    add_idle(4'b0000, 2'd0);

    // Round-robin with all requesting: 0,1,2,3,0 each for a full burst
    for (int g = 0; g < 5; g++) begin
      add_idle(4'b1111, (g == 0) ? 2'd0 : 2'(g - 1));
      for (int k = 0; k < MAX_BURST; k++) add_busy(4'b1111, 1'b1, 2'(g), 1'b1, 1'b1);
    end
    add_idle(4'b0000, 2'd0);

    // Single requester 1: full burst, bubble, re-grant, stall, drop with ready
    add_idle(4'b0010, 2'd0);
    for (int k = 0; k < MAX_BURST; k++) add_busy(4'b0010, 1'b1, 2'd1, 1'b1, 1'b1);
    add_idle(4'b0010, 2'd1);
    add_busy(4'b0010, 1'b1, 2'd1, 1'b1, 1'b1);
    add_busy(4'b0010, 1'b0, 2'd1, 1'b1, 1'b0);
    add_busy(4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
    add_idle(4'b0000, 2'd1);

    // Backpressure on requester 3: burst still totals MAX_BURST
    add_idle(4'b1000, 2'd1);
    add_busy(4'b1000, 1'b1, 2'd3, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) add_busy(4'b1000, 1'b0, 2'd3, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) add_busy(4'b1000, 1'b1, 2'd3, 1'b1, 1'b1);
    add_idle(4'b0000, 2'd3);

    // Early drop by requester 0, next grant must go to requester 2
    add_idle(4'b0001, 2'd3);
    add_busy(4'b0101, 1'b1, 2'd0, 1'b1, 1'b1);
    add_busy(4'b0100, 1'b1, 2'd0, 1'b0, 1'b0);
    add_idle(4'b0101, 2'd0);
    for (int k = 0; k < MAX_BURST; k++) add_busy(4'b0101, 1'b1, 2'd2, 1'b1, 1'b1);

    // Pointer wrap: 3 then 0
    add_idle(4'b1001, 2'd2);
    for (int k = 0; k < MAX_BURST; k++) add_busy(4'b1001, 1'b1, 2'd3, 1'b1, 1'b1);
    add_idle(4'b1001, 2'd3);
    for (int k = 0; k < MAX_BURST; k++) add_busy(4'b1001, 1'b1, 2'd0, 1'b1, 1'b1);
    add_idle(4'b0000, 2'd0);

    // Lead-in to the mid-burst reset: requester 2, two beats
    add_idle(4'b0100, 2'd0);
    add_busy(4'b0100, 1'b1, 2'd2, 1'b1, 1'b1);
    add_busy(4'b0100, 1'b1, 2'd2, 1'b1, 1'b1);

    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      apply(vec[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-burst (cnt=2), away from any clock edge
    @(posedge clk);
    #3;
    hv.rst = 1'b1; hv.req = 4'b0100; hv.rdy = 1'b1;
    hv.e_gnt = 4'b0000; hv.e_sel = 2'd0; hv.e_valid = 1'b0; hv.e_ack = 4'b0000;
    apply(hv, "async_rst");
    @(negedge clk);
    apply(hv, "rst_held");
    hv.rst = 1'b0; hv.req = 4'b0000;
    @(negedge clk);
    apply(hv, "post_rst_idle0");
    @(negedge clk);
    apply(hv, "post_rst_idle1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4-to-1 data multiplexer. Four requesters compete for one downstream channel. The block grants one requester at a time, drives the mux select lines and forwards the granted requester's data beats through a valid/ready handshake. A grant ends when the requester drops its request or reaches a burst limit, and fairness is kept by a rotating priority pointer.

## Interface
- WIDTH, 8, data width of each requester and of the output
- MAX_BURST, 4, maximum accepted beats per grant (1..255)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  request per requester; bit i = requester i
- a, b, c, d  input  WIDTH each  data of requesters 0, 1, 2, 3
- gnt  output  4  one-hot grant, registered
- s1, s2  output  1 each  mux selects, registered; {s1,s2} = index of the granted requester (00=a, 01=b, 10=c, 11=d)
- o  output  WIDTH  selected data, combinational mux of a/b/c/d by {s1,s2}
- o_valid  output  1  beat present on o
- o_ready  input  1  downstream accepts beat
- ack  output  4  one-hot, high in the cycle requester i's beat is accepted

## Operation
- There are two states, IDLE and BUSY. Internal registers are a 2-bit priority pointer ptr and an 8-bit beat counter cnt.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select the first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the clock edge set gnt to that bit, load {s1,s2} with its index, clear cnt and go to BUSY.
- BUSY:
  - o_valid = req[{s1,s2}].
  - ack = gnt when o_valid & o_ready, else 0.
  - On an accepted beat, cnt increments.
- Release from BUSY to IDLE happens at the clock edge when either condition holds:
  - (a) req[{s1,s2}] == 0; no beat is transferred that cycle.
  - (b) an accepted beat makes cnt+1 == MAX_BURST.
- On release:
  - gnt clears to 0.
  - ptr becomes {s1,s2}+1 mod 4 (wraps 3 to 0).
  - {s1,s2} holds its last value.
- Requests from non-granted requesters are ignored while BUSY; they wait for the next arbitration.
- Requests and grants:
  - A requester keeps its req high and its data stable until it sees ack.
  - Data may change after each ack.
- In IDLE, o_valid = 0 and ack = 0.
- A stall (o_ready = 0) holds the state, does not advance cnt, and keeps o and o_valid stable as long as req stays high.
- Reset:
  - Reset values: gnt=0, s1=0, s2=0, ptr=0, cnt=0, state IDLE. Consequently o_valid=0, ack=0 and o=a.
  - Reset mid-burst aborts the burst immediately. No ack is issued in or after the reset cycle.

## Timing
- Request to grant: a req seen in IDLE at edge k gives gnt, s1 and s2 valid after edge k, so the first beat is possible in cycle k+1.
- o_valid and o follow the registered selects with no extra delay. ack is combinational in the same cycle as o_valid & o_ready.
- Throughput: one beat per cycle while granted and o_ready = 1.
- Every release costs one IDLE cycle before the next grant (a bubble), including a re-grant to the same requester.
- Release on burst limit happens at the same edge as the last accepted beat.
- Release on a dropped req happens at the first edge where the req is low.
- If req drops in the same cycle o_ready rises, no beat is transferred, because o_valid is low.
- gnt is never multi-hot, and gnt = 0 in IDLE.

## Test plan
- **Reset values:** assert rst mid-burst (requester 2 granted, cnt=2) -> gnt=0000, s1=s2=0, o_valid=0, ack=0000 immediately and asynchronously. After release with req=0000, state stays IDLE.
- **Single requester:** req=0010, b=8'hA5, o_ready=1, MAX_BURST=4 -> gnt=0010 and {s1,s2}=01 one cycle after req. Then four ack pulses on bit 1 with o=A5, then gnt=0000 for one cycle, then re-grant to 0010.
- **Round-robin fairness:** req=1111 held, MAX_BURST=2, o_ready=1 -> grants in order 0001, 0010, 0100, 1000, 0001, each giving 2 beats with a one-cycle gap between grants.
- **Backpressure:** requester 3 granted, o_ready low for 3 cycles -> o_valid=1, o=d stable, ack=0000 and cnt unchanged. Beats resume when o_ready=1 and the burst still totals MAX_BURST.
- **Early drop:** requester 0 granted, req[0] falls after 1 accepted beat with req=0101 -> release, ptr=1, and the next grant goes to requester 2 (0100), not requester 0.
- **Wrap-around:** ptr=3 after a release from requester 2, req=1001 -> grant 1000. After that release, ptr=0 and req=1001 -> grant 0001.
